kb_input_sched: RTL
===================

Name: kb_input_sched

Overview:
- Sequencer between the PS/2 keyboard driver and the CPU's keyboard MMIO port.
- Turns the driver's level-style key outputs into discrete key events:
  - new press → one event;
  - held key → typematic auto-repeat;
  - driver error → timed driver clear and recovery.
- Buffers events in a first-word-fall-through FIFO that the CPU drains one entry per read strobe.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- REPEAT_DELAY, 25000000, cycles from first event of a held key to first repeat (500 ms at 50 MHz).
- REPEAT_RATE, 5000000, cycles between subsequent repeats (100 ms).
- RECOVER_CYCLES, 16, cycles drv_clr is held high after a driver error.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- clrn  in  1  reset; synchronous, active-high.
- key_code  in  8  driver key output; 0 means no key held.
- key_special  in  1  driver special-key (arrow) flag.
- key_ctrl  in  1  driver Ctrl-held flag.
- key_error  in  1  driver error flag.
- drv_clr  out  1  clear to driver (active-high, same polarity as clrn).
- rd_en  in  1  CPU pop strobe.
- rd_data  out  9  FIFO head: bit8 = special, bits7:0 = code; 0 when empty.
- fifo_empty  out  1  FIFO empty.
- fifo_count  out  DEPTH_LOG2+1  entries held.
- overflow  out  1  sticky: an event was dropped on full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset, applied on the clock edge where clrn=1:
  - state=IDLE; FIFO pointers and count=0; fifo_empty=1; rd_data=0; overflow=0; drv_clr=0; timer=0; last_code=0.
  - A reset mid-repeat or mid-recovery aborts it and drops all FIFO contents.
- Inputs are registered once before use. All event decisions use the registered values.
- Event word = {key_special, mapped code}. Without the optional feature, mapped code = key_code.
- FSM states and transitions:
  - IDLE:
    - key_error=1 → RECOVER.
    - key_code≠0 → push event, last_code=key_code, timer=0, → HELD.
  - HELD:
    - key_error=1 → RECOVER.
    - key_code=0 → IDLE.
    - key_code≠last_code and ≠0 → push new event, last_code updated, timer=0, stay HELD.
    - timer reaches REPEAT_DELAY-1 → push repeat, timer=0, → REPEAT.
  - REPEAT:
    - key_error, release and key-change behave as in HELD. A key change returns to HELD.
    - timer reaches REPEAT_RATE-1 → push repeat, timer=0.
  - RECOVER:
    - drv_clr=1 for exactly RECOVER_CYCLES cycles; key inputs ignored.
    - Then drv_clr=0, last_code=0, → IDLE.
    - A key still held on IDLE entry produces a fresh event.
- Push latency: event enters FIFO on the edge after the registered input change. fifo_empty falls on that same edge.
- FIFO:
  - Push while full: event dropped, overflow←1, contents unchanged.
  - rd_en with FIFO not empty: head advances, count-1.
  - rd_en with FIFO empty: ignored, no underflow.
  - Push and pop on the same cycle: both take effect, count unchanged. Push is accepted even when full.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- overflow clears on ovf_clr. If ovf_clr and a drop land on the same cycle, set wins.
- key_ctrl/key_special toggling with an unchanged key_code produces no event.

Optional Feature:
- KB_CTRL_MAP_EN defined:
  - When key_ctrl=1, key_special=0 and code is in 0x61..0x7A, the mapped code = code-0x60 (0x01..0x1A). Repeats use the mapped code.
  - All other codes pass unchanged.
- Undefined: key_ctrl is ignored and codes pass unchanged.

Test Plan:
- Reset, then key_code 0x00→0x61 held 10 cycles → exactly one entry, rd_data=0x061. rd_en → fifo_empty=1, rd_data=0.
- Using REPEAT_DELAY=100, REPEAT_RATE=20: hold 0x62 for 200 cycles → 1+1+4 = 6 entries of 0x062. Release → no further pushes.
- key_special=1, key_code=0x75 → rd_data=0x175. Change to 0x72 while held → second entry 0x172, repeat timer restarted.
- Push 17 distinct presses with no reads → fifo_count=16, overflow=1, head=first code. ovf_clr → overflow=0. Then simultaneous rd_en + new press → count stays 16.
- key_error pulse during REPEAT → drv_clr high exactly 16 cycles, no pushes during it. Key held after recovery → one new entry.
- With KB_CTRL_MAP_EN, key_ctrl=1, key_code=0x63 → 0x003. Without the macro → 0x063.

Source files
------------

// File: rtl/kb_input_sched.sv
// kb_input_sched: turns PS/2 driver key levels into press/typematic events buffered in a FWFT FIFO.
// Define KB_CTRL_MAP_EN to fold Ctrl+lowercase letters (0x61..0x7A) into control codes 0x01..0x1A.
module kb_input_sched #(
    parameter int DEPTH_LOG2     = 4,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_RATE    = 5000000,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic                CLOCK_50,
    input  logic                clrn,
    input  logic [7:0]          key_code,
    input  logic                key_special,
    input  logic                key_ctrl,
    input  logic                key_error,
    output logic                drv_clr,
    input  logic                rd_en,
    output logic [8:0]          rd_data,
    output logic                fifo_empty,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int T_MAX_A = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int T_MAX   = (T_MAX_A > RECOVER_CYCLES) ? T_MAX_A : RECOVER_CYCLES;
    localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0]       DELAY_LAST   = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]       RATE_LAST    = TW'(REPEAT_RATE - 1);
    localparam logic [TW-1:0]       RECOVER_LAST = TW'(RECOVER_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT   = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, HELD, REPEAT, RECOVER} state_t;

    logic [7:0]            code_q;
    logic                  special_q;
    logic                  ctrl_q;
    logic                  error_q;
    state_t                state;
    state_t                state_n;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_n;
    logic [7:0]            last_code;
    logic [7:0]            last_code_n;
    logic                  push;
    logic                  repeat_due;
    logic [7:0]            mapped_code;
    logic [8:0]            event_word;
    logic [8:0]            mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  pop;
    logic                  do_write;
    logic                  drop;

    always_ff @(posedge CLOCK_50) begin
        if (clrn) begin
            code_q    <= '0;
            special_q <= 1'b0;
            ctrl_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            code_q    <= key_code;
            special_q <= key_special;
            ctrl_q    <= key_ctrl;
            error_q   <= key_error;
        end
    end

`ifdef KB_CTRL_MAP_EN
    always_comb begin
        mapped_code = code_q;
        if (ctrl_q && !special_q && (code_q >= 8'h61) && (code_q <= 8'h7A))
            mapped_code = code_q - 8'h60;
    end
`else
    logic ctrl_unused;
    assign ctrl_unused = ctrl_q;
    assign mapped_code = code_q;
`endif

    // Repeats are built from the live registered inputs, which match last_code whenever one fires.
    assign event_word = {special_q, mapped_code};
    assign repeat_due = (state == HELD) ? (timer == DELAY_LAST) : (timer == RATE_LAST);
    assign drv_clr    = (state == RECOVER);

    always_ff @(posedge CLOCK_50) begin
        if (clrn) begin
            state     <= IDLE;
            timer     <= '0;
            last_code <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            last_code <= last_code_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        last_code_n = last_code;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (error_q) begin
                    state_n = RECOVER;
                    timer_n = '0;
                end else if (code_q != 8'h00) begin
                    push        = 1'b1;
                    last_code_n = code_q;
                    timer_n     = '0;
                    state_n     = HELD;
                end
            end
            HELD, REPEAT: begin
                if (error_q) begin
                    state_n = RECOVER;
                    timer_n = '0;
                end else if (code_q == 8'h00) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (code_q != last_code) begin
                    push        = 1'b1;
                    last_code_n = code_q;
                    timer_n     = '0;
                    state_n     = HELD;
                end else if (repeat_due) begin
                    push    = 1'b1;
                    timer_n = '0;
                    state_n = REPEAT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RECOVER: begin
                if (timer == RECOVER_LAST) begin
                    state_n     = IDLE;
                    timer_n     = '0;
                    last_code_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    // A pop frees the slot a same-cycle push needs, so a full FIFO only drops when not being read.
    assign full       = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign fifo_count = count;
    assign pop        = rd_en && !fifo_empty;
    assign do_write   = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign rd_data    = fifo_empty ? 9'h000 : mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (do_write)
            mem[wr_ptr] <= event_word;
    end

    always_ff @(posedge CLOCK_50) begin
        if (clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !pop)
                count <= count + 1'b1;
            else if (pop && !do_write)
                count <= count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
